ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Pipeline boundary register between the EX stage (ALU) and the MEM stage of the 5-stage MIPS CPU.
- Captures the ALU result, the store data and the decoded control for each instruction.
- Resolves beq/bne from the ALU zero flag and computes the branch target.
- Suppresses writeback on signed-overflow instructions, raises a sticky overflow exception, and counts taken branches.

Parameters:
CNT_W, 32, width of taken-branch counter br_count (wraps modulo 2^CNT_W)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
ex_valid  input  1  EX presents a valid instruction
ex_ready  output  1  stage accepts this cycle; equals ~mem_stall
ex_instr  input  32  instruction word in EX
ex_pc4  input  32  PC+4 of that instruction
ex_result  input  32  ALU result
ex_flags  input  3  ALU flags: [2] overflow, [1] negative, [0] zero
ex_rt_data  input  32  forwarded rt value (store data)
mem_stall  input  1  MEM cannot accept; hold all state
flush_in  input  1  kill held entry (external redirect)
mem_valid  output  1  registered entry valid
mem_instr  output  32  registered instruction
mem_result  output  32  registered ALU result / address
mem_wdata  output  32  registered store data
mem_wreg  output  5  destination register
mem_regwrite  output  1  writeback enable
mem_memread  output  1  lw
mem_memwrite  output  1  sw
br_taken  output  1  one-cycle redirect pulse
br_target  output  32  branch target address
exc_ovf  output  1  sticky overflow exception
exc_pc  output  32  address of the faulting instruction
exc_ack  input  1  clears exc_ovf
br_count  output  CNT_W  taken-branch count

Behaviour:
- Reset (async, rst_n=0): all outputs and internal registers 0, including mem_valid, exc_ovf, br_count and the fresh bit.
- Capture: on a rising edge with mem_stall=0:
  - mem_valid <= ex_valid & ~flush_in.
  - Data/control registers load from the ex_* inputs.
  - fresh <= 1.
  - Latency is 1 cycle.
- Hold: mem_stall=1 holds every register and sets fresh <= 0. ex_ready=0 during stall.
- Flush: flush_in=1 clears mem_valid on the edge regardless of mem_stall; flush wins over both capture and hold.
- Decode of the captured word (opcode [31:26], funct [5:0]):
  - R-type (opcode 0): mem_wreg=rd; regwrite=1 unless funct=0 with the whole word 0 (nop).
  - addi/addiu/andi/ori/xori/slti/sltiu: mem_wreg=rt, regwrite=1.
  - lw (100011): mem_wreg=rt, regwrite=1, memread=1.
  - sw (101011): memwrite=1, regwrite=0.
  - beq/bne: regwrite=0.
  - Unknown opcode: all controls 0.
  - All control outputs are gated by mem_valid.
- Overflow: applies to add (funct 100000), sub (100010) and addi (001000) when ex_flags[2]=1.
  - Captured regwrite forced to 0.
  - exc_ovf set on that edge; exc_pc <= ex_pc4-4.
  - exc_ovf stays set until exc_ack. If set and ack occur in the same edge, set wins.
  - While exc_ovf=1, a further overflow does not overwrite exc_pc.
  - Unsigned ops (addu/subu/addiu) never trap.
- Branch:
  - taken = beq & zero, or bne & ~zero, using the zero flag registered at capture.
  - br_target = pc4 + (sign-extended imm << 2), 32-bit wrap.
  - br_taken = mem_valid & fresh & taken, so it is high exactly one cycle per captured branch even under a subsequent stall.
  - br_count increments on each br_taken cycle and wraps to 0 at 2^CNT_W-1.
- br_target reflects the registered entry whether or not the branch is taken.
- Mid-operation reset clears everything immediately (async), with no pending pulse afterwards.

Test Plan:
- Reset mid-stream: assert rst_n=0 with mem_valid=1 and exc_ovf=1 -> all outputs 0 within the same cycle; br_count=0.
- beq taken: ex_instr=0x10000003, ex_pc4=0x00000010, ex_flags=3'b001, ex_valid=1 -> next cycle br_taken=1, br_target=0x0000001C, regwrite=0, br_count=1. br_taken stays 1 for exactly one cycle while mem_stall=1 is held for 3 cycles.
- bne not taken: ex_instr=0x14220002, ex_flags=3'b001 -> br_taken=0, br_count unchanged.
- Signed overflow: ex_instr=0x00011020 (add $2,$0,$1), ex_pc4=0x40, ex_flags=3'b100 -> mem_regwrite=0, exc_ovf=1, exc_pc=0x3C. Pulse exc_ack -> exc_ovf=0 next edge. Same word as addu (0x00011021) -> mem_regwrite=1, mem_wreg=2, no trap.
- lw/sw capture: lw 0x8C430004 with ex_result=0x100 -> mem_memread=1, mem_wreg=3, mem_result=0x100. sw 0xAC430004 with ex_rt_data=0xDEADBEEF -> mem_memwrite=1, mem_wdata=0xDEADBEEF, regwrite=0.
- Stall+flush collision: mem_stall=1 and flush_in=1 on the same edge -> mem_valid=0, ex_ready=0. Then release the stall with ex_valid=1 -> capture resumes next edge.

Source files
------------

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// ex_mem_stage : EX/MEM pipeline register with branch resolve, overflow trap
//                and taken-branch counter for the 5-stage MIPS pipeline.
// Revision     : 1.0
// ============================================================================
module ex_mem_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [31:0]      ex_instr,
  input  logic [31:0]      ex_pc4,
  input  logic [31:0]      ex_result,
  input  logic [2:0]       ex_flags,
  input  logic [31:0]      ex_rt_data,
  input  logic             mem_stall,
  input  logic             flush_in,
  output logic             mem_valid,
  output logic [31:0]      mem_instr,
  output logic [31:0]      mem_result,
  output logic [31:0]      mem_wdata,
  output logic [4:0]       mem_wreg,
  output logic             mem_regwrite,
  output logic             mem_memread,
  output logic             mem_memwrite,
  output logic             br_taken,
  output logic [31:0]      br_target,
  output logic             exc_ovf,
  output logic [31:0]      exc_pc,
  input  logic             exc_ack,
  output logic [CNT_W-1:0] br_count
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;
  localparam logic [5:0] c_OP_SLTIU = 6'b001011;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_XORI  = 6'b001110;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_FN_ADD   = 6'b100000;
  localparam logic [5:0] c_FN_SUB   = 6'b100010;

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_wreg;
  logic        w_rw;
  logic        w_mr;
  logic        w_mw;
  logic        w_beq;
  logic        w_bne;
  logic        w_signed;
  logic        w_trap;
  logic        w_accept;
  logic        w_taken_in;
  logic        w_unused_flags;

  logic             valid_q;
  logic [31:0]      instr_q;
  logic [31:0]      pc4_q;
  logic [31:0]      result_q;
  logic [31:0]      wdata_q;
  logic [4:0]       wreg_q;
  logic             rw_q;
  logic             mr_q;
  logic             mw_q;
  logic             taken_q;
  logic             fresh_q;
  logic             exc_ovf_q, exc_ovf_d;
  logic [31:0]      exc_pc_q, exc_pc_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;

  assign w_op           = ex_instr[31:26];
  assign w_funct        = ex_instr[5:0];
  assign w_unused_flags = ex_flags[1];

  always_comb begin
    w_wreg   = 5'd0;
    w_rw     = 1'b0;
    w_mr     = 1'b0;
    w_mw     = 1'b0;
    w_beq    = 1'b0;
    w_bne    = 1'b0;
    w_signed = 1'b0;
    case (w_op)
      c_OP_RTYPE: begin
        w_wreg   = ex_instr[15:11];
        w_rw     = |ex_instr;
        w_signed = (w_funct == c_FN_ADD) || (w_funct == c_FN_SUB);
      end
      c_OP_ADDI: begin
        w_wreg   = ex_instr[20:16];
        w_rw     = 1'b1;
        w_signed = 1'b1;
      end
      c_OP_ADDIU, c_OP_SLTI, c_OP_SLTIU, c_OP_ANDI, c_OP_ORI, c_OP_XORI: begin
        w_wreg = ex_instr[20:16];
        w_rw   = 1'b1;
      end
      c_OP_LW: begin
        w_wreg = ex_instr[20:16];
        w_rw   = 1'b1;
        w_mr   = 1'b1;
      end
      c_OP_SW:  w_mw  = 1'b1;
      c_OP_BEQ: w_beq = 1'b1;
      c_OP_BNE: w_bne = 1'b1;
      default: ;
    endcase
  end

  assign w_trap     = w_signed & ex_flags[2];
  assign w_accept   = ex_valid & ~flush_in & ~mem_stall;
  assign w_taken_in = (w_beq & ex_flags[0]) | (w_bne & ~ex_flags[0]);

  // A trap on the accepted edge beats a simultaneous acknowledge; the first
  // faulting PC is kept until software clears the exception.
  always_comb begin
    exc_ovf_d  = (w_accept & w_trap) | (exc_ovf_q & ~exc_ack);
    exc_pc_d   = (w_accept & w_trap & ~exc_ovf_q) ? (ex_pc4 - 32'd4) : exc_pc_q;
    br_count_d = br_count_q + {{(CNT_W-1){1'b0}}, (w_accept & w_taken_in)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= 32'd0;
      pc4_q      <= 32'd0;
      result_q   <= 32'd0;
      wdata_q    <= 32'd0;
      wreg_q     <= 5'd0;
      rw_q       <= 1'b0;
      mr_q       <= 1'b0;
      mw_q       <= 1'b0;
      taken_q    <= 1'b0;
      fresh_q    <= 1'b0;
      exc_ovf_q  <= 1'b0;
      exc_pc_q   <= 32'd0;
      br_count_q <= '0;
    end else begin
      if (mem_stall) begin
        fresh_q <= 1'b0;
        if (flush_in) begin
          valid_q <= 1'b0;
        end
      end else begin
        valid_q  <= ex_valid & ~flush_in;
        instr_q  <= ex_instr;
        pc4_q    <= ex_pc4;
        result_q <= ex_result;
        wdata_q  <= ex_rt_data;
        wreg_q   <= w_wreg;
        rw_q     <= w_rw & ~w_trap;
        mr_q     <= w_mr;
        mw_q     <= w_mw;
        taken_q  <= w_taken_in;
        fresh_q  <= 1'b1;
      end
      exc_ovf_q  <= exc_ovf_d;
      exc_pc_q   <= exc_pc_d;
      br_count_q <= br_count_d;
    end
  end

  assign ex_ready     = ~mem_stall;
  assign mem_valid    = valid_q;
  assign mem_instr    = instr_q;
  assign mem_result   = result_q;
  assign mem_wdata    = wdata_q;
  assign mem_wreg     = valid_q ? wreg_q : 5'd0;
  assign mem_regwrite = valid_q & rw_q;
  assign mem_memread  = valid_q & mr_q;
  assign mem_memwrite = valid_q & mw_q;
  // fresh_q limits the redirect to the first cycle of an entry held by stall
  assign br_taken     = valid_q & fresh_q & taken_q;
  assign br_target    = pc4_q + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign exc_ovf      = exc_ovf_q;
  assign exc_pc       = exc_pc_q;
  assign br_count     = br_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_ex_mem_stage : table vectors, directed corner sequences and random
//                   stimulus against a behavioural model of ex_mem_stage.
// Revision        : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ex_mem_stage;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ex_valid;
  logic             ex_ready;
  logic [31:0]      ex_instr;
  logic [31:0]      ex_pc4;
  logic [31:0]      ex_result;
  logic [2:0]       ex_flags;
  logic [31:0]      ex_rt_data;
  logic             mem_stall;
  logic             flush_in;
  logic             mem_valid;
  logic [31:0]      mem_instr;
  logic [31:0]      mem_result;
  logic [31:0]      mem_wdata;
  logic [4:0]       mem_wreg;
  logic             mem_regwrite;
  logic             mem_memread;
  logic             mem_memwrite;
  logic             br_taken;
  logic [31:0]      br_target;
  logic             exc_ovf;
  logic [31:0]      exc_pc;
  logic             exc_ack;
  logic [CNT_W-1:0] br_count;

  always #5 clk = ~clk;

  ex_mem_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_instr(ex_instr), .ex_pc4(ex_pc4), .ex_result(ex_result),
    .ex_flags(ex_flags), .ex_rt_data(ex_rt_data), .mem_stall(mem_stall),
    .flush_in(flush_in), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_result(mem_result), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg),
    .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .br_taken(br_taken), .br_target(br_target),
    .exc_ovf(exc_ovf), .exc_pc(exc_pc), .exc_ack(exc_ack), .br_count(br_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic rw, mr, mw, beq, bne; logic [4:0] wreg; } ctl_t;
  typedef struct packed {
    logic valid; logic [31:0] instr, pc4, result, wdata; logic zero, ovf;
  } entry_t;

  entry_t           m_e;
  logic             m_pending;
  logic             m_exc;
  logic [31:0]      m_excpc;
  logic [CNT_W-1:0] m_cnt;

  function automatic ctl_t f_ctl(input logic [31:0] w);
    ctl_t c;
    c = '0;
    case (w[31:26])
      6'h00: begin c.wreg = w[15:11]; c.rw = (w != 32'd0); end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin c.wreg = w[20:16]; c.rw = 1'b1; end
      6'h23: begin c.wreg = w[20:16]; c.rw = 1'b1; c.mr = 1'b1; end
      6'h2B: c.mw = 1'b1;
      6'h04: c.beq = 1'b1;
      6'h05: c.bne = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic f_signed_op(input logic [31:0] w);
    return (w[31:26] == 6'h00 && (w[5:0] == 6'h20 || w[5:0] == 6'h22)) || (w[31:26] == 6'h08);
  endfunction

  function automatic logic f_taken(input entry_t e);
    ctl_t c;
    c = f_ctl(e.instr);
    return (c.beq && e.zero) || (c.bne && !e.zero);
  endfunction

  function automatic logic [31:0] f_target(input entry_t e);
    logic signed [31:0] off;
    off = 32'($signed(e.instr[15:0]));
    return e.pc4 + 32'(off * 4);
  endfunction

  task automatic model_reset();
    m_e = '0; m_pending = 1'b0; m_exc = 1'b0; m_excpc = 32'd0; m_cnt = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (ex_valid && !flush_in && !mem_stall && f_signed_op(ex_instr) && ex_flags[2]) begin
        if (!m_exc) m_excpc = ex_pc4 - 32'd4;
        m_exc = 1'b1;
      end else if (exc_ack) begin
        m_exc = 1'b0;
      end
      if (mem_stall) begin
        m_pending = 1'b0;
        if (flush_in) m_e.valid = 1'b0;
      end else begin
        m_e = '{ex_valid && !flush_in, ex_instr, ex_pc4, ex_result, ex_rt_data,
                ex_flags[0], ex_flags[2] && f_signed_op(ex_instr)};
        m_pending = 1'b1;
        if (m_e.valid && f_taken(m_e)) m_cnt = m_cnt + 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    ctl_t c;
    c = f_ctl(m_e.instr);
    check({tag, "_valid"}, 64'(mem_valid), 64'(m_e.valid));
    check({tag, "_instr"}, 64'(mem_instr), 64'(m_e.instr));
    check({tag, "_result"}, 64'(mem_result), 64'(m_e.result));
    check({tag, "_wdata"}, 64'(mem_wdata), 64'(m_e.wdata));
    check({tag, "_wreg"}, 64'(mem_wreg), 64'(m_e.valid ? c.wreg : 5'd0));
    check({tag, "_regwrite"}, 64'(mem_regwrite), 64'(m_e.valid && c.rw && !m_e.ovf));
    check({tag, "_memread"}, 64'(mem_memread), 64'(m_e.valid && c.mr));
    check({tag, "_memwrite"}, 64'(mem_memwrite), 64'(m_e.valid && c.mw));
    check({tag, "_br_taken"}, 64'(br_taken), 64'(m_e.valid && m_pending && f_taken(m_e)));
    check({tag, "_br_target"}, 64'(br_target), 64'(f_target(m_e)));
    check({tag, "_exc_ovf"}, 64'(exc_ovf), 64'(m_exc));
    check({tag, "_exc_pc"}, 64'(exc_pc), 64'(m_excpc));
    check({tag, "_br_count"}, 64'(br_count), 64'(m_cnt));
    check({tag, "_ex_ready"}, 64'(ex_ready), 64'(!mem_stall));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc4,
                       input logic [31:0] res, input logic [31:0] rtd, input logic [2:0] fl,
                       input logic st, input logic fl_in, input logic ack);
    ex_valid = v; ex_instr = ins; ex_pc4 = pc4; ex_result = res; ex_rt_data = rtd;
    ex_flags = fl; mem_stall = st; flush_in = fl_in; exc_ack = ack;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic v; logic [31:0] instr, pc4, result, rtd; logic [2:0] flags; logic flush;
    logic e_valid; logic [4:0] e_wreg; logic e_rw, e_mr, e_mw, e_bt; logic [31:0] e_tgt;
  } vec_t;
  vec_t vt[15];

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops[14];
    logic [31:0] w;
    logic [5:0] fn[5];
    ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
            6'h23, 6'h2B, 6'h04, 6'h05, 6'h0F};
    fn  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24};
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 13)];
    if (w[31:26] == 6'h00) w[5:0] = fn[$urandom_range(0, 4)];
    if ($urandom_range(0, 19) == 0) w = 32'd0;
    return w;
  endfunction

  initial begin
    vt[0]  = '{1'b1, 32'h10000003, 32'h10,  32'h0,   32'h0,        3'b001, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1C};
    vt[1]  = '{1'b1, 32'h14220002, 32'h20,  32'h0,   32'h0,        3'b001, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h28};
    vt[2]  = '{1'b1, 32'h14220002, 32'h20,  32'h0,   32'h0,        3'b000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h28};
    vt[3]  = '{1'b1, 32'h1000FFFF, 32'h100, 32'h0,   32'h0,        3'b001, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFC};
    vt[4]  = '{1'b1, 32'h00011021, 32'h40,  32'h5,   32'h0,        3'b100, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40C4};
    vt[5]  = '{1'b1, 32'h00011020, 32'h40,  32'h5,   32'h0,        3'b100, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40C0};
    vt[6]  = '{1'b1, 32'h8C430004, 32'h50,  32'h100, 32'h0,        3'b000, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h60};
    vt[7]  = '{1'b1, 32'hAC430004, 32'h50,  32'h104, 32'hDEADBEEF, 3'b000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h60};
    vt[8]  = '{1'b1, 32'h00000000, 32'h0,   32'h0,   32'h0,        3'b000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 32'h20220005, 32'h0,   32'h7,   32'h0,        3'b000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h14};
    vt[10] = '{1'b1, 32'h3C010001, 32'h0,   32'h0,   32'h0,        3'b000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4};
    vt[11] = '{1'b1, 32'h20220005, 32'h0,   32'h0,   32'h0,        3'b100, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h14};
    vt[12] = '{1'b1, 32'h34430010, 32'h0,   32'h0,   32'h0,        3'b000, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40};
    vt[13] = '{1'b1, 32'h8C430004, 32'h0,   32'h0,   32'h0,        3'b000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10};
    vt[14] = '{1'b1, 32'h10000003, 32'h10,  32'h0,   32'h0,        3'b000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1C};

    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    model_reset();
    step("reset");
    step("reset2");
    rst_n = 1'b1;

    // beq taken, then a 3-cycle stall must not repeat the redirect
    drive(1'b1, 32'h10000003, 32'h10, 32'h0, 32'h0, 3'b001, 1'b0, 1'b0, 1'b0);
    step("beq");
    check("beq_taken", 64'(br_taken), 64'(1'b1));
    check("beq_target", 64'(br_target), 64'(32'h1C));
    check("beq_count", 64'(br_count), 64'(32'd1));
    check("beq_regwrite", 64'(mem_regwrite), 64'(1'b0));
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("beq_stall");
      check($sformatf("beq_stall%0d_taken", i), 64'(br_taken), 64'(1'b0));
      check($sformatf("beq_stall%0d_valid", i), 64'(mem_valid), 64'(1'b1));
      check($sformatf("beq_stall%0d_count", i), 64'(br_count), 64'(32'd1));
    end

    drive(1'b1, 32'h14220002, 32'h20, 32'h0, 32'h0, 3'b001, 1'b0, 1'b0, 1'b0);
    step("bne_nt");
    check("bne_nt_taken", 64'(br_taken), 64'(1'b0));
    check("bne_nt_count", 64'(br_count), 64'(32'd1));

    // signed overflow, sticky PC, set-beats-ack, then ack alone
    drive(1'b1, 32'h00011020, 32'h40, 32'h0, 32'h0, 3'b100, 1'b0, 1'b0, 1'b0);
    step("ovf");
    check("ovf_regwrite", 64'(mem_regwrite), 64'(1'b0));
    check("ovf_exc", 64'(exc_ovf), 64'(1'b1));
    check("ovf_pc", 64'(exc_pc), 64'(32'h3C));
    drive(1'b1, 32'h20220005, 32'h80, 32'h0, 32'h0, 3'b100, 1'b0, 1'b0, 1'b1);
    step("ovf2");
    check("ovf2_exc", 64'(exc_ovf), 64'(1'b1));
    check("ovf2_pc", 64'(exc_pc), 64'(32'h3C));
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b1);
    step("ack");
    check("ack_exc", 64'(exc_ovf), 64'(1'b0));
    drive(1'b1, 32'h00011021, 32'h40, 32'h0, 32'h0, 3'b100, 1'b0, 1'b0, 1'b0);
    step("addu");
    check("addu_regwrite", 64'(mem_regwrite), 64'(1'b1));
    check("addu_wreg", 64'(mem_wreg), 64'(5'd2));
    check("addu_exc", 64'(exc_ovf), 64'(1'b0));

    // stall and flush on the same edge
    drive(1'b1, 32'h00011021, 32'h40, 32'h0, 32'h0, 3'b000, 1'b1, 1'b1, 1'b0);
    step("stflush");
    check("stflush_valid", 64'(mem_valid), 64'(1'b0));
    check("stflush_ready", 64'(ex_ready), 64'(1'b0));
    drive(1'b1, 32'h8C430004, 32'h50, 32'h100, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    step("resume");
    check("resume_valid", 64'(mem_valid), 64'(1'b1));
    check("resume_memread", 64'(mem_memread), 64'(1'b1));
    check("resume_result", 64'(mem_result), 64'(32'h100));

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].v, vt[i].instr, vt[i].pc4, vt[i].result, vt[i].rtd, vt[i].flags,
            1'b0, vt[i].flush, 1'b0);
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d_valid", i), 64'(mem_valid), 64'(vt[i].e_valid));
      check($sformatf("vec%0d_wreg", i), 64'(mem_wreg), 64'(vt[i].e_wreg));
      check($sformatf("vec%0d_regwrite", i), 64'(mem_regwrite), 64'(vt[i].e_rw));
      check($sformatf("vec%0d_memread", i), 64'(mem_memread), 64'(vt[i].e_mr));
      check($sformatf("vec%0d_memwrite", i), 64'(mem_memwrite), 64'(vt[i].e_mw));
      check($sformatf("vec%0d_br_taken", i), 64'(br_taken), 64'(vt[i].e_bt));
      check($sformatf("vec%0d_br_target", i), 64'(br_target), 64'(vt[i].e_tgt));
      check($sformatf("vec%0d_result", i), 64'(mem_result), 64'(vt[i].result));
      check($sformatf("vec%0d_wdata", i), 64'(mem_wdata), 64'(vt[i].rtd));
    end

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 4) != 0, rand_instr(), $urandom, $urandom, $urandom,
            3'($urandom_range(0, 7)), $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
      step("rand");
    end

    // asynchronous reset with a valid entry and a pending exception
    drive(1'b1, 32'h00011020, 32'h40, 32'h0, 32'h0, 3'b100, 1'b0, 1'b0, 1'b0);
    step("pre_rst");
    check("pre_rst_exc", 64'(exc_ovf), 64'(1'b1));
    check("pre_rst_valid", 64'(mem_valid), 64'(1'b1));
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst_count", 64'(br_count), 64'(32'd0));
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0);
    step("rst_hold");
    rst_n = 1'b1;
    step("post_rst");
    check("post_rst_taken", 64'(br_taken), 64'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
